// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and constants for the integer register file.
// Pure definitions: no logic, no latency, no backpressure.
package reg_file_mp_pkg;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_REG_COUNT = 32;
    localparam int DEF_ADDR_W    = $clog2(DEF_REG_COUNT);
    localparam int REG_X0        = 0;

    localparam logic [DEF_ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [DEF_WIDTH-1:0]  DATA_ZERO = '0;
endpackage

// File: rtl/reg_file_mp_read.sv
// One read port: x0 masking, port A over port B bypass, RAW busy flag.
// Latency: fully combinational. No backpressure; busy flag is the stall signal.
module rf_read_bypass
    import reg_file_mp_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic [ADDR_W-1:0]                rd_addr,
    input  logic [REG_COUNT-1:0][WIDTH-1:0]  regs,
    input  logic [REG_COUNT-1:0]             pending,
    input  logic                             we_a,
    input  logic [ADDR_W-1:0]                waddr_a,
    input  logic [WIDTH-1:0]                 wdata_a,
    input  logic                             we_b,
    input  logic [ADDR_W-1:0]                waddr_b,
    input  logic [WIDTH-1:0]                 wdata_b,
    output logic [WIDTH-1:0]                 rd_data,
    output logic                             rd_busy
);
    logic is_x0;
    logic hit_a;
    logic hit_b;

    always_comb begin
        is_x0 = (rd_addr == ADDR_W'(REG_X0));
        hit_a = we_a && (waddr_a == rd_addr);
        hit_b = we_b && (waddr_b == rd_addr);

        rd_data = '0;
        if (!is_x0) begin
            if (hit_a)
                rd_data = wdata_a;
            else if (hit_b)
                rd_data = wdata_b;
            else
                rd_data = regs[rd_addr];
        end

        // An M-unit result arriving this cycle is already forwarded, so no stall.
        rd_busy = pending[rd_addr] & ~hit_b;
    end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port RV32IM register file with write-through bypass and long-latency scoreboard.
// Latency: reads/busy combinational; writes and scoreboard visible after the next edge.
// No backpressure: decode stalls on RdBusy; writes are always accepted.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int NUM_RD    = 2,
    localparam int ADDR_W   = $clog2(REG_COUNT),
    localparam int CNT_W    = $clog2(REG_COUNT + 1)
) (
    input  logic                       CPU_clk,
    input  logic                       CPU_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
    output logic [NUM_RD*WIDTH-1:0]    RdData,
    output logic [NUM_RD-1:0]          RdBusy,
    input  logic                       WeA,
    input  logic [ADDR_W-1:0]          WaddrA,
    input  logic [WIDTH-1:0]           WdataA,
    input  logic                       WeB,
    input  logic [ADDR_W-1:0]          WaddrB,
    input  logic [WIDTH-1:0]           WdataB,
    input  logic                       IssueValid,
    input  logic [ADDR_W-1:0]          IssueAddr,
    output logic [REG_COUNT-1:0]       Pending,
    output logic [CNT_W-1:0]           PendCnt
);
    logic [REG_COUNT-1:0][WIDTH-1:0] mem_q;
    logic [REG_COUNT-1:0]            pending_q;
    logic [REG_COUNT-1:0]            pend_next;
    logic [REG_COUNT-1:0]            set_vec;
    logic [REG_COUNT-1:0]            clr_vec;
    logic [REG_COUNT-1:0]            wr_a_vec;
    logic [CNT_W-1:0]                cnt_q;
    logic [CNT_W-1:0]                cnt_next;
    logic                            cnt_inc;
    logic                            cnt_dec;
    logic                            byp_we_a;
    logic                            byp_we_b;

    // Index 0 is left out of every decode, so x0 never stores or goes pending.
    always_comb begin
        set_vec  = '0;
        clr_vec  = '0;
        wr_a_vec = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            set_vec[r]  = IssueValid && (IssueAddr == ADDR_W'(r));
            clr_vec[r]  = WeB && (WaddrB == ADDR_W'(r));
            wr_a_vec[r] = WeA && (WaddrA == ADDR_W'(r));
        end
        pend_next = set_vec | (pending_q & ~clr_vec);
        cnt_inc   = |(set_vec & ~pending_q);
        cnt_dec   = |(clr_vec & ~set_vec & pending_q);
        cnt_next  = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end

    always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n) begin
            mem_q     <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (wr_a_vec[r])
                    mem_q[r] <= WdataA;
                else if (clr_vec[r])
                    mem_q[r] <= WdataB;
            end
            pending_q <= pend_next;
            cnt_q     <= cnt_next;
        end
    end

    assign Pending = pending_q;
    assign PendCnt = cnt_q;

    // Bypass is masked during reset so every read port returns zero.
    assign byp_we_a = WeA & CPU_rst_n;
    assign byp_we_b = WeB & CPU_rst_n;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_bypass #(
            .WIDTH     (WIDTH),
            .REG_COUNT (REG_COUNT),
            .ADDR_W    (ADDR_W)
        ) u_rd (
            .rd_addr (RdAddr[k*ADDR_W +: ADDR_W]),
            .regs    (mem_q),
            .pending (pending_q),
            .we_a    (byp_we_a),
            .waddr_a (WaddrA),
            .wdata_a (WdataA),
            .we_b    (byp_we_b),
            .waddr_b (WaddrB),
            .wdata_b (WdataB),
            .rd_data (RdData[k*WIDTH +: WIDTH]),
            .rd_busy (RdBusy[k])
        );
    end
endmodule
